// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: bus widths, FSM encodings, wait default.
package imem_arbiter_pkg;

  localparam int unsigned INST_ADDR_BUS_W     = 32;
  localparam int unsigned INST_BUS_W          = 32;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 1;

  localparam logic [INST_BUS_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic                  CHIP_ENABLE  = 1'b1;
  localparam logic                  CHIP_DISABLE = 1'b0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch port, loader port and single-port memory signals around the arbiter.
interface imem_arbiter_if;
  import imem_arbiter_pkg::*;

  logic                       if_req;
  logic [INST_ADDR_BUS_W-1:0] if_addr;
  logic [INST_BUS_W-1:0]      if_inst;
  logic                       if_ack;
  logic                       stallreq;
  logic                       ld_req;
  logic                       ld_we;
  logic [INST_ADDR_BUS_W-1:0] ld_addr;
  logic [INST_BUS_W-1:0]      ld_wdata;
  logic [INST_BUS_W-1:0]      ld_rdata;
  logic                       ld_ack;
  logic                       mem_ce;
  logic                       mem_we;
  logic [INST_ADDR_BUS_W-1:0] mem_addr;
  logic [INST_BUS_W-1:0]      mem_wdata;
  logic [INST_BUS_W-1:0]      mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output if_inst, if_ack, stallreq, ld_rdata, ld_ack, mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  if_inst, if_ack, stallreq, ld_rdata, ld_ack, mem_ce, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction memory between fetch and loader ports.
// Optional feature macro IMEM_LD_WRITE_EN enables loader writes; otherwise loader accesses are reads.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  imem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  logic [1:0]                 state_r;
  logic [CNT_W-1:0]           cnt_r;
  logic                       last_ld_r;
  logic                       grant_ld_r;
  logic [INST_ADDR_BUS_W-1:0] addr_r;
  logic [INST_BUS_W-1:0]      wdata_r;
  logic                       we_r;
  logic                       if_ack_r;
  logic                       ld_ack_r;
  logic [INST_BUS_W-1:0]      if_inst_r;
  logic [INST_BUS_W-1:0]      ld_rdata_r;
  logic                       pick_ld_s;
  logic                       we_next_s;
  logic                       access_s;

  // Loader wins when fetch is idle, or when both request and fetch had the previous grant.
  assign pick_ld_s = bus.ld_req & (~bus.if_req | ~last_ld_r);

`ifdef IMEM_LD_WRITE_EN
  assign we_next_s = pick_ld_s & bus.ld_we;
`else
  logic unused_ld_we_s;
  assign unused_ld_we_s = bus.ld_we;
  assign we_next_s      = 1'b0;
`endif

  assign access_s      = (state_r == ST_ACCESS);
  assign bus.mem_ce    = access_s ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.mem_we    = access_s & we_r;
  assign bus.mem_addr  = access_s ? addr_r  : ZERO_WORD;
  assign bus.mem_wdata = access_s ? wdata_r : ZERO_WORD;
  assign bus.if_ack    = if_ack_r;
  assign bus.ld_ack    = ld_ack_r;
  assign bus.if_inst   = if_inst_r;
  assign bus.ld_rdata  = ld_rdata_r;
  assign bus.stallreq  = bus.if_req & ~if_ack_r;

  // Arbitration FSM, wait counter and one-cycle ack/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      last_ld_r  <= 1'b1;
      grant_ld_r <= 1'b0;
      addr_r     <= ZERO_WORD;
      wdata_r    <= ZERO_WORD;
      we_r       <= 1'b0;
      if_ack_r   <= 1'b0;
      ld_ack_r   <= 1'b0;
      if_inst_r  <= ZERO_WORD;
      ld_rdata_r <= ZERO_WORD;
    end else begin
      if_ack_r   <= 1'b0;
      ld_ack_r   <= 1'b0;
      if_inst_r  <= ZERO_WORD;
      ld_rdata_r <= ZERO_WORD;
      case (state_r)
        ST_IDLE: begin
          if (bus.if_req | bus.ld_req) begin
            grant_ld_r <= pick_ld_s;
            last_ld_r  <= pick_ld_s;
            addr_r     <= pick_ld_s ? bus.ld_addr  : bus.if_addr;
            wdata_r    <= pick_ld_s ? bus.ld_wdata : ZERO_WORD;
            we_r       <= we_next_s;
            cnt_r      <= WAIT_LOAD;
            state_r    <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_DONE;
            if (grant_ld_r) begin
              ld_ack_r   <= 1'b1;
              ld_rdata_r <= we_r ? ZERO_WORD : bus.mem_rdata;
            end else begin
              if_ack_r  <= 1'b1;
              if_inst_r <= bus.mem_rdata;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
